// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register for the in-order 5-stage RV32I core. Besides
// registering the write-back value and destination, it carries the valid bit,
// applies stall/flush from the hazard unit, performs load byte/halfword
// selection with sign or zero extension, picks the write-back source,
// suppresses writes to x0 and counts instructions captured into WB.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   stall, flush    hold the stage / insert a bubble (flush has priority)
//   mem_valid       MEM-stage instruction valid
//   alu_result      ALU result, also the load effective address
//   mem_rdata       aligned data-memory read word
//   pc_plus4        link value for JAL/JALR
//   rd_mem          destination register
//   reg_write_mem   instruction writes rd
//   wb_sel_mem      00 ALU, 01 load, 10 PC+4, 11 ALU
//   load_funct3     load type (LB/LH/LW/LBU/LHU/LWU)
//   wb_valid        WB-stage instruction valid
//   wb_data         registered write-back value
//   rd_wb           registered destination register
//   reg_write_wb    register-file write enable
//   retired_count   number of valid instructions captured into WB
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  reg_write_mem,
  input  logic [1:0]            wb_sel_mem,
  input  logic [2:0]            load_funct3,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_data,
  output logic [REG_ADDR_W-1:0] rd_wb,
  output logic                  reg_write_wb,
  output logic [CNT_W-1:0]      retired_count
);

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  logic [31:0]           load_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       wb_value;
  logic                  write_qual;

  logic                  wb_valid_d,     wb_valid_q;
  logic [XLEN-1:0]       wb_data_d,      wb_data_q;
  logic [REG_ADDR_W-1:0] rd_wb_d,        rd_wb_q;
  logic                  reg_write_wb_d, reg_write_wb_q;
  logic [CNT_W-1:0]      retired_cnt_d,  retired_cnt_q;

  // Load alignment and extension. Only the low 32 bits of the read word are
  // meaningful; a halfword is picked by address bit 1 alone, so a misaligned
  // halfword silently reads the enclosing aligned halfword.
  always_comb begin
    load_word = mem_rdata[31:0];
    byte_sel  = load_word[7:0];
    half_sel  = alu_result[1] ? load_word[31:16] : load_word[15:0];
    load_data = XLEN'($signed(load_word));

    case (alu_result[1:0])
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase

    case (load_funct3)
      3'b000:  load_data = XLEN'($signed(byte_sel));
      3'b100:  load_data = XLEN'(byte_sel);
      3'b001:  load_data = XLEN'($signed(half_sel));
      3'b101:  load_data = XLEN'(half_sel);
      3'b110:  load_data = XLEN'(load_word);
      // LW and every unused encoding: sign-extended low word
      default: load_data = XLEN'($signed(load_word));
    endcase
  end

  // Write-back source select and x0 write suppression.
  always_comb begin
    wb_value = alu_result;
    case (wb_sel_mem)
      WB_SEL_ALU:  wb_value = alu_result;
      WB_SEL_LOAD: wb_value = load_data;
      WB_SEL_PC4:  wb_value = pc_plus4;
      default:     wb_value = alu_result;
    endcase
    write_qual = mem_valid & reg_write_mem & (rd_mem != '0);
  end

  // Next-state for the stage registers. Flush beats stall; on a flush the data
  // word is left alone because nothing downstream looks at it without a valid
  // write enable. The counter only moves on an actual capture of a valid
  // instruction, so it lines up with wb_valid rising on the same edge.
  always_comb begin
    wb_valid_d     = wb_valid_q;
    wb_data_d      = wb_data_q;
    rd_wb_d        = rd_wb_q;
    reg_write_wb_d = reg_write_wb_q;
    retired_cnt_d  = retired_cnt_q;

    if (flush) begin
      wb_valid_d     = 1'b0;
      rd_wb_d        = '0;
      reg_write_wb_d = 1'b0;
    end else if (!stall) begin
      wb_valid_d     = mem_valid;
      wb_data_d      = wb_value;
      rd_wb_d        = rd_mem;
      reg_write_wb_d = write_qual;
      if (mem_valid) begin
        retired_cnt_d = retired_cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage registers with synchronous reset that overrides stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      rd_wb_q        <= '0;
      reg_write_wb_q <= 1'b0;
      retired_cnt_q  <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      rd_wb_q        <= rd_wb_d;
      reg_write_wb_q <= reg_write_wb_d;
      retired_cnt_q  <= retired_cnt_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign rd_wb         = rd_wb_q;
  assign reg_write_wb  = reg_write_wb_q;
  assign retired_count = retired_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Directed testbench for mem_wb_stage. Two instances share the same stimulus:
// the default 32-bit-counter configuration and a CNT_W=4 configuration used to
// observe counter wrap. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, well away from the next active edge.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] pc_plus4;
  logic [4:0]  rd_mem;
  logic        reg_write_mem;
  logic [1:0]  wb_sel_mem;
  logic [2:0]  load_funct3;

  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic [31:0] retired_count;

  logic        wb_valid4;
  logic [31:0] wb_data4;
  logic [4:0]  rd_wb4;
  logic        reg_write_wb4;
  logic [3:0]  retired_count4;

  int numChecks;
  int numErrors;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .pc_plus4(pc_plus4), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .wb_sel_mem(wb_sel_mem), .load_funct3(load_funct3),
    .wb_valid(wb_valid), .wb_data(wb_data), .rd_wb(rd_wb),
    .reg_write_wb(reg_write_wb), .retired_count(retired_count)
  );

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .pc_plus4(pc_plus4), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .wb_sel_mem(wb_sel_mem), .load_funct3(load_funct3),
    .wb_valid(wb_valid4), .wb_data(wb_data4), .rd_wb(rd_wb4),
    .reg_write_wb(reg_write_wb4), .retired_count(retired_count4)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one set of MEM-stage inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] sel,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [31:0] pc,
                               input logic [2:0] f3);
    mem_valid     = v;
    reg_write_mem = rw;
    wb_sel_mem    = sel;
    rd_mem        = rd;
    alu_result    = alu;
    mem_rdata     = rdata;
    pc_plus4      = pc;
    load_funct3   = f3;
    @(posedge clk);
    #1;
  endtask

  // One valid load into x6 from the fixed test word, then check the result.
  task automatic runLoad(input string tag, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_1000 | 32'(off),
                  32'h80FF_7F01, 32'h0, f3);
    checkOutput(tag, wb_data, expected);
  endtask

  initial begin
    numChecks = 0;
    numErrors = 0;
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 3'b010);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 3'b010);
    checkOutput("rst_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_data", wb_data, 32'h0);
    checkOutput("rst_rd", 32'(rd_wb), 32'd0);
    checkOutput("rst_we", 32'(reg_write_wb), 32'd0);
    checkOutput("rst_cnt", retired_count, 32'd0);
    checkOutput("rst_cnt4", 32'(retired_count4), 32'd0);
    rst = 1'b0;

    // Three ALU ops to x1..x3
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 5'(i), 32'(i * 16), 32'h0, 32'h0, 3'b010);
      checkOutput("alu_data", wb_data, 32'(i * 16));
      checkOutput("alu_rd", 32'(rd_wb), 32'(i));
      checkOutput("alu_we", 32'(reg_write_wb), 32'd1);
      checkOutput("alu_valid", 32'(wb_valid), 32'd1);
    end
    checkOutput("alu_cnt", retired_count, 32'd3);

    // Loads from 0x80FF7F01
    runLoad("lb_off2",   3'b000, 2'd2, 32'hFFFF_FFFF);
    runLoad("lbu_off3",  3'b100, 2'd3, 32'h0000_0080);
    runLoad("lh_off0",   3'b001, 2'd0, 32'h0000_7F01);
    runLoad("lh_off2",   3'b001, 2'd2, 32'hFFFF_80FF);
    runLoad("lhu_off2",  3'b101, 2'd2, 32'h0000_80FF);
    runLoad("lw",        3'b010, 2'd0, 32'h80FF_7F01);
    runLoad("lb_off1",   3'b000, 2'd1, 32'h0000_007F);
    runLoad("lh_off3",   3'b001, 2'd3, 32'hFFFF_80FF);
    runLoad("lwu",       3'b110, 2'd0, 32'h80FF_7F01);
    runLoad("f3_111_lw", 3'b111, 2'd0, 32'h80FF_7F01);
    checkOutput("load_cnt", retired_count, 32'd13);

    // Write to x0 is suppressed but the instruction is still valid
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd0, 32'h55, 32'h0, 32'h0, 3'b010);
    checkOutput("x0_valid", 32'(wb_valid), 32'd1);
    checkOutput("x0_we", 32'(reg_write_wb), 32'd0);
    checkOutput("x0_data", wb_data, 32'h55);

    // JAL link value
    applyStimulus(1'b1, 1'b1, 2'b10, 5'd1, 32'h999, 32'h0, 32'h104, 3'b010);
    checkOutput("jal_data", wb_data, 32'h104);
    checkOutput("jal_we", 32'(reg_write_wb), 32'd1);

    // wb_sel 11 falls back to ALU
    applyStimulus(1'b1, 1'b1, 2'b11, 5'd2, 32'h77, 32'h1234, 32'h500, 3'b010);
    checkOutput("sel11_data", wb_data, 32'h77);

    // Invalid instruction still loads data and rd but never writes
    applyStimulus(1'b0, 1'b1, 2'b00, 5'd7, 32'h88, 32'h0, 32'h0, 3'b010);
    checkOutput("inv_valid", 32'(wb_valid), 32'd0);
    checkOutput("inv_data", wb_data, 32'h88);
    checkOutput("inv_rd", 32'(rd_wb), 32'd7);
    checkOutput("inv_we", 32'(reg_write_wb), 32'd0);
    checkOutput("inv_cnt", retired_count, 32'd16);

    // Two-cycle stall with changing inputs
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd8, 32'hA0, 32'h0, 32'h0, 3'b010);
    checkOutput("pre_stall_cnt", retired_count, 32'd17);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd9, 32'hB0, 32'h0, 32'h0, 3'b010);
    checkOutput("stall1_data", wb_data, 32'hA0);
    checkOutput("stall1_rd", 32'(rd_wb), 32'd8);
    checkOutput("stall1_cnt", retired_count, 32'd17);
    applyStimulus(1'b0, 1'b0, 2'b10, 5'd11, 32'hB4, 32'h0, 32'h200, 3'b010);
    checkOutput("stall2_data", wb_data, 32'hA0);
    checkOutput("stall2_valid", 32'(wb_valid), 32'd1);
    checkOutput("stall2_we", 32'(reg_write_wb), 32'd1);
    checkOutput("stall2_cnt", retired_count, 32'd17);
    stall = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd10, 32'hC0, 32'h0, 32'h0, 3'b010);
    checkOutput("unstall_data", wb_data, 32'hC0);
    checkOutput("unstall_rd", 32'(rd_wb), 32'd10);
    checkOutput("unstall_cnt", retired_count, 32'd18);

    // Flush together with stall inserts a bubble; data word holds
    stall = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd5, 32'hD0, 32'h0, 32'h0, 3'b010);
    checkOutput("flush_valid", 32'(wb_valid), 32'd0);
    checkOutput("flush_rd", 32'(rd_wb), 32'd0);
    checkOutput("flush_we", 32'(reg_write_wb), 32'd0);
    checkOutput("flush_data", wb_data, 32'hC0);
    checkOutput("flush_cnt", retired_count, 32'd18);
    stall = 1'b0;
    flush = 1'b0;

    // 18 captures so far: the 4-bit counter has wrapped to 2
    checkOutput("cnt4_18", 32'(retired_count4), 32'd2);

    // Reset wins over stall
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd3, 32'hE0, 32'h0, 32'h0, 3'b010);
    rst   = 1'b1;
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd4, 32'hF0, 32'h0, 32'h0, 3'b010);
    checkOutput("rststall_valid", 32'(wb_valid), 32'd0);
    checkOutput("rststall_data", wb_data, 32'h0);
    checkOutput("rststall_rd", 32'(rd_wb), 32'd0);
    checkOutput("rststall_we", 32'(reg_write_wb), 32'd0);
    checkOutput("rststall_cnt", retired_count, 32'd0);
    checkOutput("rststall_cnt4", 32'(retired_count4), 32'd0);
    rst   = 1'b0;
    stall = 1'b0;

    // 17 valid captures: the 4-bit counter wraps through 15 -> 0 -> 1
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 5'd1, 32'(i), 32'h0, 32'h0, 3'b010);
    end
    checkOutput("cnt4_15", 32'(retired_count4), 32'd15);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd1, 32'h0, 32'h0, 32'h0, 3'b010);
    checkOutput("cnt4_wrap0", 32'(retired_count4), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd1, 32'h0, 32'h0, 32'h0, 3'b010);
    checkOutput("cnt4_17", 32'(retired_count4), 32'd1);
    checkOutput("cnt32_17", retired_count, 32'd17);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
